// File: rtl/iomem_uart_bridge.sv
// iomem_uart_bridge
//   Debug initiator for the iomem peripheral bus, driven from a UART byte stream.
//   Commands (big-endian fields):
//     'R' (0x52) + addr[4]           -> reply rdata[4] MSB first, or 'T' on bus timeout
//     'W' (0x57) + addr[4] + data[4] -> reply 'K', or 'T' on bus timeout
//   Ports:
//     clk, reset              clock and synchronous active-high reset
//     rx_valid, rx_data       received byte strobe and byte
//     tx_valid, tx_ready,
//     tx_data                 response byte stream (valid/ready handshake)
//     overrun                 one-cycle pulse when a byte arrives while busy
//     iomem_*                 single-transaction initiator port
module iomem_uart_bridge #(
  parameter int BUS_TIMEOUT = 255,
  parameter int GAP_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        overrun,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  // Abort is decided in the cycle the counter would reach its limit.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_TIMEOUT);
  localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_MAX  = BW'(BUS_TIMEOUT);

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [1:0]    resp_last_q, resp_last_d;  // index of final response byte
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] bus_q, bus_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          valid_q, valid_d;
  logic [31:0]   resp_q, resp_d;            // current tx byte lives in [31:24]
  logic          tx_valid_q, tx_valid_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      resp_last_q <= '0;
      gap_q       <= '0;
      bus_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      valid_q     <= 1'b0;
      resp_q      <= '0;
      tx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      resp_last_q <= resp_last_d;
      gap_q       <= gap_d;
      bus_q       <= bus_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      valid_q     <= valid_d;
      resp_q      <= resp_d;
      tx_valid_q  <= tx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    resp_last_d = resp_last_q;
    gap_d       = gap_q;
    bus_d       = bus_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    valid_d     = valid_q;
    resp_d      = resp_q;
    tx_valid_d  = tx_valid_q;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Unknown opcodes are silently skipped; they are not overruns.
        if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
          is_write_d = (rx_data == CMD_WRITE);
          byte_cnt_d = '0;
          gap_d      = '0;
          state_d    = ADDR;
        end
      end

      ADDR, DATA: begin
        if (rx_valid) begin
          gap_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ADDR) addr_d  = {addr_q[23:0], rx_data};
          else                 wdata_d = {wdata_q[23:0], rx_data};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == ADDR && is_write_q) begin
              state_d = DATA;
            end else begin
              // Request goes out registered with the last byte.
              state_d = BUS;
              valid_d = 1'b1;
              wstrb_d = is_write_q ? 4'hF : 4'h0;
              bus_d   = '0;
            end
          end
        end else if (gap_q >= GAP_LAST) begin
          gap_d   = GAP_MAX;
          state_d = IDLE;
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
      end

      BUS: begin
        if (rx_valid) overrun_d = 1'b1;
        if (valid_q && iomem_ready) begin
          // Ready is checked first so it wins over a simultaneous timeout.
          valid_d    = 1'b0;
          tx_valid_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = RESP;
          if (is_write_q) begin
            resp_d      = {RSP_OK, 24'h0};
            resp_last_d = 2'd0;
          end else begin
            resp_d      = iomem_rdata;
            resp_last_d = 2'd3;
          end
        end else if (valid_q) begin
          if (bus_q >= BUS_LAST) begin
            bus_d       = BUS_MAX;
            valid_d     = 1'b0;
            tx_valid_d  = 1'b1;
            byte_cnt_d  = '0;
            resp_d      = {RSP_TMO, 24'h0};
            resp_last_d = 2'd0;
            state_d     = RESP;
          end else begin
            bus_d = bus_q + 1'b1;
          end
        end
      end

      RESP: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_valid_q && tx_ready) begin
          if (byte_cnt_q == resp_last_q) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            resp_d     = {resp_q[23:0], 8'h00};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = resp_q[31:24];
  assign overrun     = overrun_q;
  assign iomem_valid = valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;

endmodule
